alu_reservation_station: RTL and testbench

Buffers issued integer/branch/jump/AUIPC micro-ops until both source operands are available, and dispatches one ready entry per cycle to the ALU. It sits between the issue stage and the ALU: it takes instructions from issue, snoops the two CDB broadcast ports for operand wakeup, and drives the ALU's `_alu_*` input bus. It flushes on `_clear`, the ROB mispredict flush.

---
 rtl/alu_reservation_station_pkg.sv | 38 +++
 rtl/alu_reservation_station_if.sv | 34 +++
 rtl/alu_reservation_station_select.sv | 21 ++
 rtl/alu_reservation_station.sv | 108 ++++++++++
 tb/tb_alu_reservation_station.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
package rs_pkg;
   localparam int ROB_W  = 5;
   localparam int TYPE_W = 7;
   localparam int OP_W   = 4;
   localparam int XLEN   = 32;

   localparam logic [TYPE_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [TYPE_W-1:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [TYPE_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [TYPE_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [TYPE_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [TYPE_W-1:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic              busy;
      logic [ROB_W-1:0]  rob_id;
      logic [TYPE_W-1:0] typ;
      logic [OP_W-1:0]   op;
      logic [XLEN-1:0]   v1;
      logic [XLEN-1:0]   v2;
      logic              q1_busy;
      logic              q2_busy;
      logic [ROB_W-1:0]  q1;
      logic [ROB_W-1:0]  q2;
   } rs_entry_t;

   // Resolve one operand against both CDB ports; returns {still_busy, value}.
   // The ALU port is tested first so it wins a (buggy) double match.
   function automatic logic [XLEN:0] cdb_snoop(
      input logic qb, input logic [ROB_W-1:0] q, input logic [XLEN-1:0] v,
      input logic a_rdy, input logic [ROB_W-1:0] a_id, input logic [XLEN-1:0] a_val,
      input logic l_rdy, input logic [ROB_W-1:0] l_id, input logic [XLEN-1:0] l_val);
      if (qb && a_rdy && q == a_id) return {1'b0, a_val};
      if (qb && l_rdy && q == l_id) return {1'b0, l_val};
      return {qb, v};
   endfunction
endpackage

// File: rtl/alu_reservation_station_if.sv
// Issue, CDB snoop and ALU dispatch buses of the reservation station.
interface alu_reservation_station_if #(parameter int ROB_W = 5);
   logic             _issue_valid;
   logic [ROB_W-1:0] _issue_rob_id;
   logic [6:0]       _issue_type;
   logic [3:0]       _issue_op;
   logic [31:0]      _issue_v1, _issue_v2;
   logic             _issue_q1_busy, _issue_q2_busy;
   logic [ROB_W-1:0] _issue_q1, _issue_q2;
   logic             _rs_full;
   logic             _cdb_alu_ready, _cdb_lsb_ready;
   logic [ROB_W-1:0] _cdb_alu_rob_id, _cdb_lsb_rob_id;
   logic [31:0]      _cdb_alu_value, _cdb_lsb_value;
   logic             _alu_ready;
   logic [ROB_W-1:0] _alu_rob_id;
   logic [6:0]       _alu_type;
   logic [3:0]       _alu_op;
   logic [31:0]      _alu_v1, _alu_v2;

   modport master (
      output _issue_valid, _issue_rob_id, _issue_type, _issue_op, _issue_v1, _issue_v2,
             _issue_q1_busy, _issue_q2_busy, _issue_q1, _issue_q2,
             _cdb_alu_ready, _cdb_lsb_ready, _cdb_alu_rob_id, _cdb_lsb_rob_id,
             _cdb_alu_value, _cdb_lsb_value,
      input  _rs_full, _alu_ready, _alu_rob_id, _alu_type, _alu_op, _alu_v1, _alu_v2
   );
   modport slave (
      input  _issue_valid, _issue_rob_id, _issue_type, _issue_op, _issue_v1, _issue_v2,
             _issue_q1_busy, _issue_q2_busy, _issue_q1, _issue_q2,
             _cdb_alu_ready, _cdb_lsb_ready, _cdb_alu_rob_id, _cdb_lsb_rob_id,
             _cdb_alu_value, _cdb_lsb_value,
      output _rs_full, _alu_ready, _alu_rob_id, _alu_type, _alu_op, _alu_v1, _alu_v2
   );
endinterface

// File: rtl/alu_reservation_station_select.sv
// Lowest-index priority encoder: request vector -> index of first set bit.
module rs_select #(
   parameter  int N     = 8,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             found
);
   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds issued ops until both operands are known,
// snoops the CDB for wakeup and dispatches the lowest ready entry per cycle.
module alu_reservation_station #(
   parameter int RS_DEPTH = 8,
   parameter int ROB_W    = rs_pkg::ROB_W
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic rdy_in,
   input  logic _clear,
   alu_reservation_station_if.slave bus
);
   import rs_pkg::*;

   localparam int IDX_W = $clog2(RS_DEPTH);

   rs_entry_t           ent [RS_DEPTH];
   rs_entry_t           nxt [RS_DEPTH];
   rs_entry_t           iss;
   logic [RS_DEPTH-1:0] free_vec, rdy_vec;
   logic [IDX_W-1:0]    free_idx, sel_idx;
   logic                free_found, sel_found;

   logic                alu_ready_q;
   logic [ROB_W-1:0]    alu_rob_q;
   logic [TYPE_W-1:0]   alu_type_q;
   logic [OP_W-1:0]     alu_op_q;
   logic [XLEN-1:0]     alu_v1_q, alu_v2_q;

   // Free and ready masks are judged on pre-edge state only.
   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         free_vec[i] = !ent[i].busy;
         rdy_vec[i]  = ent[i].busy && !ent[i].q1_busy && !ent[i].q2_busy;
      end
   end

   rs_select #(.N(RS_DEPTH)) u_free_sel (.req(free_vec), .idx(free_idx), .found(free_found));
   rs_select #(.N(RS_DEPTH)) u_rdy_sel  (.req(rdy_vec),  .idx(sel_idx),  .found(sel_found));

   assign bus._rs_full = !free_found;

   // Next entry state: wakeup, dispatch release and issue (with CDB bypass).
   always_comb begin
      iss         = '0;
      iss.busy    = 1'b1;
      iss.rob_id  = bus._issue_rob_id;
      iss.typ     = bus._issue_type;
      iss.op      = bus._issue_op;
      iss.q1      = bus._issue_q1;
      iss.q2      = bus._issue_q2;
      {iss.q1_busy, iss.v1} = cdb_snoop(bus._issue_q1_busy, bus._issue_q1, bus._issue_v1,
         bus._cdb_alu_ready, bus._cdb_alu_rob_id, bus._cdb_alu_value,
         bus._cdb_lsb_ready, bus._cdb_lsb_rob_id, bus._cdb_lsb_value);
      {iss.q2_busy, iss.v2} = cdb_snoop(bus._issue_q2_busy, bus._issue_q2, bus._issue_v2,
         bus._cdb_alu_ready, bus._cdb_alu_rob_id, bus._cdb_alu_value,
         bus._cdb_lsb_ready, bus._cdb_lsb_rob_id, bus._cdb_lsb_value);
      for (int i = 0; i < RS_DEPTH; i++) begin
         nxt[i] = ent[i];
         if (ent[i].busy) begin
            {nxt[i].q1_busy, nxt[i].v1} = cdb_snoop(ent[i].q1_busy, ent[i].q1, ent[i].v1,
               bus._cdb_alu_ready, bus._cdb_alu_rob_id, bus._cdb_alu_value,
               bus._cdb_lsb_ready, bus._cdb_lsb_rob_id, bus._cdb_lsb_value);
            {nxt[i].q2_busy, nxt[i].v2} = cdb_snoop(ent[i].q2_busy, ent[i].q2, ent[i].v2,
               bus._cdb_alu_ready, bus._cdb_alu_rob_id, bus._cdb_alu_value,
               bus._cdb_lsb_ready, bus._cdb_lsb_rob_id, bus._cdb_lsb_value);
         end
         if (sel_found && sel_idx == IDX_W'(i)) nxt[i].busy = 1'b0;
      end
      // Free slot comes from the pre-edge set, so it never equals sel_idx.
      if (bus._issue_valid && free_found) nxt[free_idx] = iss;
   end

   // Entry and dispatch registers; clear beats everything, stall holds all.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
         alu_ready_q <= 1'b0;
         alu_rob_q   <= '0;
         alu_type_q  <= '0;
         alu_op_q    <= '0;
         alu_v1_q    <= '0;
         alu_v2_q    <= '0;
      end else if (rdy_in) begin
         if (_clear) begin
            for (int i = 0; i < RS_DEPTH; i++) ent[i].busy <= 1'b0;
            alu_ready_q <= 1'b0;
         end else begin
            for (int i = 0; i < RS_DEPTH; i++) ent[i] <= nxt[i];
            alu_ready_q <= sel_found;
            if (sel_found) begin
               alu_rob_q  <= ent[sel_idx].rob_id;
               alu_type_q <= ent[sel_idx].typ;
               alu_op_q   <= ent[sel_idx].op;
               alu_v1_q   <= ent[sel_idx].v1;
               alu_v2_q   <= ent[sel_idx].v2;
            end
         end
      end
   end

   assign bus._alu_ready  = alu_ready_q;
   assign bus._alu_rob_id = alu_rob_q;
   assign bus._alu_type   = alu_type_q;
   assign bus._alu_op     = alu_op_q;
   assign bus._alu_v1     = alu_v1_q;
   assign bus._alu_v2     = alu_v2_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: a slot-array reference model
// predicts each dispatch, a negedge monitor pops and compares.
module tb_alu_reservation_station;
   logic clk_in, rst_in, rdy_in, clr;

   alu_reservation_station_if #(.ROB_W(5)) bus ();

   alu_reservation_station #(.RS_DEPTH(8), .ROB_W(5)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clr), .bus(bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      bit        busy;
      bit [4:0]  rob;
      bit [6:0]  typ;
      bit [3:0]  op;
      bit [31:0] v1, v2;
      bit        w1, w2;
      bit [4:0]  t1, t2;
   } ment_t;

   typedef struct packed {
      logic [4:0]  rob;
      logic [6:0]  typ;
      logic [3:0]  op;
      logic [31:0] v1, v2;
   } dsp_t;

   ment_t m [8];
   ment_t p [8];
   dsp_t  exp_q [$];
   dsp_t  p_item, last_pl;
   bit    p_push, p_rdy;
   bit    exp_alu_rdy, exp_full, rdy_edge;
   int    passed, total;

   localparam bit [6:0] OPCS [6] = '{7'b0110011, 7'b0010011, 7'b1100011,
                                     7'b1101111, 7'b1100111, 7'b0010111};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
   endtask

   task automatic chk_pl(input string nm, input dsp_t got, input dsp_t want);
      chk({nm, "_rob"},  32'(got.rob), 32'(want.rob));
      chk({nm, "_type"}, 32'(got.typ), 32'(want.typ));
      chk({nm, "_op"},   32'(got.op),  32'(want.op));
      chk({nm, "_v1"},   got.v1, want.v1);
      chk({nm, "_v2"},   got.v2, want.v2);
   endtask

   // Operand capture from the CDB this cycle; ALU port has priority.
   function automatic bit [32:0] wk(input bit w, input bit [4:0] t, input bit [31:0] v);
      if (w && bus._cdb_alu_ready && t == bus._cdb_alu_rob_id) return {1'b0, bus._cdb_alu_value};
      if (w && bus._cdb_lsb_ready && t == bus._cdb_lsb_rob_id) return {1'b0, bus._cdb_lsb_value};
      return {w, v};
   endfunction

   // Predict the state after the coming edge from current inputs.
   task automatic model_eval();
      int d, f;
      p      = m;
      p_push = 1'b0;
      p_rdy  = exp_alu_rdy;
      d      = -1;
      f      = -1;
      if (!rst_in) begin
         foreach (p[i]) p[i].busy = 1'b0;
         p_rdy = 1'b0;
      end else if (!rdy_in) begin
         p_rdy = exp_alu_rdy;
      end else if (clr) begin
         foreach (p[i]) p[i].busy = 1'b0;
         p_rdy = 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) if (d < 0 && m[i].busy && !m[i].w1 && !m[i].w2) d = i;
         for (int i = 0; i < 8; i++) if (f < 0 && !m[i].busy) f = i;
         for (int i = 0; i < 8; i++) begin
            if (m[i].busy) begin
               {p[i].w1, p[i].v1} = wk(m[i].w1, m[i].t1, m[i].v1);
               {p[i].w2, p[i].v2} = wk(m[i].w2, m[i].t2, m[i].v2);
            end
         end
         if (d >= 0) begin
            p[d].busy = 1'b0;
            p_item    = '{rob: m[d].rob, typ: m[d].typ, op: m[d].op, v1: m[d].v1, v2: m[d].v2};
            p_push    = 1'b1;
         end
         p_rdy = (d >= 0);
         if (bus._issue_valid && f >= 0) begin
            p[f].busy = 1'b1;
            p[f].rob  = bus._issue_rob_id;
            p[f].typ  = bus._issue_type;
            p[f].op   = bus._issue_op;
            p[f].t1   = bus._issue_q1;
            p[f].t2   = bus._issue_q2;
            {p[f].w1, p[f].v1} = wk(bus._issue_q1_busy, bus._issue_q1, bus._issue_v1);
            {p[f].w2, p[f].v2} = wk(bus._issue_q2_busy, bus._issue_q2, bus._issue_v2);
         end
      end
   endtask

   task automatic model_commit();
      int n;
      n = 0;
      m = p;
      foreach (m[i]) if (m[i].busy) n++;
      exp_full    = (n == 8);
      exp_alu_rdy = p_rdy;
      rdy_edge    = rst_in && rdy_in;
      if (p_push) exp_q.push_back(p_item);
   endtask

   // Inputs are already driven; advance one edge and return 1 time unit after it.
   task automatic cycle();
      model_eval();
      @(posedge clk_in);
      model_commit();
      #1;
   endtask

   task automatic idle();
      bus._issue_valid = 1'b0;  bus._issue_rob_id = '0;  bus._issue_type = '0;
      bus._issue_op = '0;       bus._issue_v1 = '0;      bus._issue_v2 = '0;
      bus._issue_q1_busy = 1'b0; bus._issue_q2_busy = 1'b0;
      bus._issue_q1 = '0;       bus._issue_q2 = '0;
      bus._cdb_alu_ready = 1'b0; bus._cdb_alu_rob_id = '0; bus._cdb_alu_value = '0;
      bus._cdb_lsb_ready = 1'b0; bus._cdb_lsb_rob_id = '0; bus._cdb_lsb_value = '0;
      clr = 1'b0;
   endtask

   task automatic issue(input bit [4:0] rob, input bit [6:0] typ, input bit [3:0] op,
                        input bit [31:0] v1, input bit [31:0] v2,
                        input bit b1, input bit [4:0] t1, input bit b2, input bit [4:0] t2);
      bus._issue_valid = 1'b1; bus._issue_rob_id = rob; bus._issue_type = typ;
      bus._issue_op = op;      bus._issue_v1 = v1;      bus._issue_v2 = v2;
      bus._issue_q1_busy = b1; bus._issue_q1 = t1;
      bus._issue_q2_busy = b2; bus._issue_q2 = t2;
   endtask

   task automatic cdb_alu(input bit [4:0] t, input bit [31:0] v);
      bus._cdb_alu_ready = 1'b1; bus._cdb_alu_rob_id = t; bus._cdb_alu_value = v;
   endtask

   task automatic cdb_lsb(input bit [4:0] t, input bit [31:0] v);
      bus._cdb_lsb_ready = 1'b1; bus._cdb_lsb_rob_id = t; bus._cdb_lsb_value = v;
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_alu_ready"}, 32'(bus._alu_ready), 0);
      chk({nm, "_alu_rob_id"}, 32'(bus._alu_rob_id), 0);
      chk({nm, "_alu_type"}, 32'(bus._alu_type), 0);
      chk({nm, "_alu_op"}, 32'(bus._alu_op), 0);
      chk({nm, "_alu_v1"}, bus._alu_v1, 0);
      chk({nm, "_alu_v2"}, bus._alu_v2, 0);
      chk({nm, "_rs_full"}, 32'(bus._rs_full), 0);
   endtask

   // Monitor: per-cycle flag checks, pop on each new dispatch, hold check on stall.
   always @(negedge clk_in) begin
      dsp_t got;
      if (rst_in) begin
         chk("alu_ready", 32'(bus._alu_ready), 32'(exp_alu_rdy));
         chk("rs_full", 32'(bus._rs_full), 32'(exp_full));
         if (bus._alu_ready) begin
            got = '{rob: bus._alu_rob_id, typ: bus._alu_type, op: bus._alu_op,
                    v1: bus._alu_v1, v2: bus._alu_v2};
            if (rdy_edge) begin
               if (exp_q.size() == 0) begin
                  total++;
                  $display("FAIL dispatch: got rob %0h, expected no dispatch at %0t", got.rob, $time);
               end else begin
                  chk_pl("dispatch", got, exp_q.pop_front());
                  last_pl = got;
               end
            end else begin
               chk_pl("stall_hold", got, last_pl);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks", total);
      $fatal(1, "watchdog");
   end

   initial begin
      passed = 0; total = 0;
      rst_in = 1'b0; rdy_in = 1'b1;
      idle();
      cycle(); cycle();
      chk_outputs_zero("in_reset");
      rst_in = 1'b1;
      cycle();
      chk_outputs_zero("after_reset");

      // Back-to-back ready issue.
      issue(5'd3, OPCS[0], 4'd0, 32'd5, 32'd7, 0, 0, 0, 0);
      cycle(); idle();
      cycle(); cycle();

      // Wakeup via LSB port two cycles after issue.
      issue(5'd4, OPCS[1], 4'd2, 32'h1111, 32'd1, 1, 5'd2, 0, 0);
      cycle(); idle();
      cycle();
      cdb_lsb(5'd2, 32'hDEAD);
      cycle(); idle();
      cycle(); cycle();

      // Issue-cycle bypass from the ALU port.
      issue(5'd6, OPCS[2], 4'd5, 32'h0, 32'd3, 1, 5'd1, 0, 0);
      cdb_alu(5'd1, 32'd9);
      cycle(); idle();
      cycle(); cycle();

      // Fill all entries, drop a 9th, then release them all.
      for (int k = 0; k < 8; k++) begin
         issue(5'(10 + k), OPCS[k % 6], 4'(k), $urandom, $urandom, 1, 5'd31, 0, 0);
         cycle();
      end
      chk("full_before_9th", 32'(bus._rs_full), 1);
      issue(5'd30, OPCS[0], 4'd1, 32'd1, 32'd2, 0, 0, 0, 0);
      cycle(); idle();
      cdb_alu(5'd31, 32'hCAFE0031);
      cycle(); idle();
      for (int k = 0; k < 10; k++) cycle();

      // Flush with a simultaneous broadcast.
      for (int k = 0; k < 5; k++) begin
         issue(5'(k), OPCS[3], 4'd7, $urandom, $urandom, 0, 0, 1, 5'd20);
         cycle();
      end
      clr = 1'b1;
      cdb_alu(5'd20, 32'h20);
      cycle(); idle();
      chk("flush_rs_full", 32'(bus._rs_full), 0);
      chk("flush_alu_ready", 32'(bus._alu_ready), 0);
      cdb_lsb(5'd20, 32'h21);
      cycle(); idle();
      for (int k = 0; k < 3; k++) cycle();

      // Stall while a dispatch is on the bus; an issue during stall is ignored.
      issue(5'd12, OPCS[5], 4'd9, 32'hAAAA, 32'hBBBB, 0, 0, 0, 0);
      cycle(); idle();
      cycle();
      rdy_in = 1'b0;
      issue(5'd13, OPCS[4], 4'd1, 32'd1, 32'd1, 0, 0, 0, 0);
      cycle(); cycle(); cycle();
      idle(); rdy_in = 1'b1;
      cycle(); cycle();

      // Asynchronous reset while a dispatch is presented.
      issue(5'd17, OPCS[0], 4'd3, 32'h77, 32'h88, 0, 0, 0, 0);
      cycle(); idle();
      issue(5'd18, OPCS[0], 4'd3, 32'h99, 32'h66, 0, 0, 0, 0);
      cycle(); idle();
      chk("pre_reset_alu_ready", 32'(bus._alu_ready), 1);
      #1 rst_in = 1'b0;
      #1 chk_outputs_zero("async_reset");
      exp_q.delete();
      last_pl = '0;
      cycle();
      rst_in = 1'b1;
      cycle();

      // Randomized traffic against the model.
      for (int c = 0; c < 300; c++) begin
         idle();
         rdy_in = ($urandom_range(9) != 0);
         clr    = ($urandom_range(39) == 0);
         if (!bus._rs_full && $urandom_range(2) != 0)
            issue(5'($urandom_range(31)), OPCS[$urandom_range(5)], 4'($urandom_range(15)),
                  $urandom, $urandom, 1'($urandom_range(1)), 5'($urandom_range(7)),
                  1'($urandom_range(1)), 5'($urandom_range(7)));
         if ($urandom_range(2) == 0) cdb_alu(5'($urandom_range(7)), $urandom);
         if ($urandom_range(2) == 0) cdb_lsb(5'($urandom_range(7)), $urandom);
         cycle();
      end

      idle(); rdy_in = 1'b1; clr = 1'b1;
      cycle(); idle();
      for (int k = 0; k < 3; k++) cycle();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
